// File: rtl/issue_stage_pkg.sv
// issue_stage_pkg
//   Shared constants and types for the in-order issue stage.
//   UNITS      : width of the one-hot execution unit select
//   LONG_MASK  : units whose results take more than one cycle (load, divide)
//   CNT_W      : width of the per-register in-flight counter
//   ipacket_t  : opaque instruction packet carried alongside each instruction
//   issue_pkt_t: contents of the issue output register
package issue_stage_pkg;

    localparam int unsigned UNITS = 8;
    localparam logic [UNITS-1:0] LONG_MASK = 8'b0000_0110;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned NREGS = 32;

    typedef logic [31:0] ipacket_t;

    typedef struct packed {
        logic [1:0][4:0]  src;
        logic [1:0]       imm_valid;
        logic [1:0][31:0] operand;
        logic [UNITS-1:0] unit;
        logic [7:0]       uop;
        ipacket_t         ipacket;
        logic [4:0]       dest;
    } issue_pkt_t;

endpackage

// File: rtl/issue_stage_scoreboard.sv
// scoreboard
//   Per-register in-flight counters and long-latency flags, with the
//   read-after-write hazard and structural-block decisions for decode.
//   clk_i, rst_n_i      : clock, synchronous active-low reset
//   flush_i             : clears every counter and flag
//   retire_i/_dest_i    : instruction leaving the issue register into the back end
//   retire_long_i       : that instruction targets a long-latency unit
//   wb_i, wb_dest_i     : writeback completing a register
//   src_i, src_used_i   : decode sources and whether each one reads a register
//   dec_dest_i          : decode destination
//   pend_*_i            : instruction currently held in the issue register
//   hazard_o, block_o   : decode must wait
module scoreboard #(
    parameter int unsigned CNT_W = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            retire_i,
    input  logic [4:0]      retire_dest_i,
    input  logic            retire_long_i,
    input  logic            wb_i,
    input  logic [4:0]      wb_dest_i,
    input  logic [1:0][4:0] src_i,
    input  logic [1:0]      src_used_i,
    input  logic [4:0]      dec_dest_i,
    input  logic            pend_valid_i,
    input  logic            pend_long_i,
    input  logic [4:0]      pend_dest_i,
    output logic            hazard_o,
    output logic            block_o
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - 1'b1;

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      long_q;
    logic [31:0]      long_d;
    logic [31:0]      inc_v;
    logic [31:0]      dec_v;

    always_comb begin
        inc_v  = '0;
        dec_v  = '0;
        long_d = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_v[r] = retire_i && (retire_dest_i == 5'(r)) && (r != 0);
            dec_v[r] = wb_i && (wb_dest_i == 5'(r)) && (r != 0);
            if (inc_v[r] && !dec_v[r]) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_v[r] && !inc_v[r] && (cnt_q[r] != '0)) begin
                // A stray writeback with nothing in flight must not wrap.
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
            long_d[r] = (cnt_d[r] == '0) ? 1'b0 : (long_q[r] | (inc_v[r] & retire_long_i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            for (int unsigned r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int unsigned r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            long_q <= long_d;
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        for (int unsigned k = 0; k < 2; k++) begin
            if (src_used_i[k]) begin
                if ((long_q[src_i[k]] && (cnt_q[src_i[k]] != '0)) ||
                    (pend_valid_i && pend_long_i && (pend_dest_i == src_i[k]))) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

    // The held instruction will still increment its counter when it retires,
    // so a counter one below saturation is also full if that instruction
    // writes the same register; otherwise back-to-back issue could wrap it.
    always_comb begin
        block_o = (cnt_q[dec_dest_i] == CNT_MAX) ||
                  (pend_valid_i && (dec_dest_i != 5'd0) && (pend_dest_i == dec_dest_i) &&
                   (cnt_q[dec_dest_i] == CNT_NEAR));
    end

endmodule

// File: rtl/issue_stage.sv
// issue_stage
//   In-order issue stage: accepts decoded instructions, reads operands from
//   the 32x32 architectural register file (with writeback write-through),
//   checks long-latency RAW hazards through the scoreboard and drives one
//   registered instruction per cycle to the back end.
//   clk_i, rst_n_i        : clock, synchronous active-low reset
//   dec_*                 : decode handshake and instruction fields
//   iss_*                 : registered issue outputs (iss_unit_valid_o=0 when idle)
//   stall_i               : back end stall, holds the issue register
//   flush_i               : trap flush, clears scoreboard and issue register
//   branch_flush_i        : taken-branch redirect, drops the issue register
//   wb_i, wb_dest_i, wb_data_i : register file writeback port
module issue_stage #(
    parameter int unsigned      UNITS     = issue_stage_pkg::UNITS,
    parameter logic [UNITS-1:0] LONG_MASK = issue_stage_pkg::LONG_MASK,
    parameter int unsigned      CNT_W     = issue_stage_pkg::CNT_W
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      dec_valid_i,
    output logic                      dec_ready_o,
    input  logic [1:0][4:0]           dec_src_i,
    input  logic [1:0]                dec_imm_valid_i,
    input  logic [31:0]               dec_imm_i,
    input  logic [4:0]                dec_dest_i,
    input  logic [UNITS-1:0]          dec_unit_i,
    input  logic [7:0]                dec_uop_i,
    input  issue_stage_pkg::ipacket_t dec_ipacket_i,
    output logic [1:0][4:0]           iss_src_o,
    output logic [1:0]                iss_imm_valid_o,
    output logic [1:0][31:0]          iss_operand_o,
    output logic [UNITS-1:0]          iss_unit_valid_o,
    output logic [7:0]                iss_uop_o,
    output issue_stage_pkg::ipacket_t iss_ipacket_o,
    input  logic                      stall_i,
    input  logic                      flush_i,
    input  logic                      branch_flush_i,
    input  logic                      wb_i,
    input  logic [4:0]                wb_dest_i,
    input  logic [31:0]               wb_data_i
);

    import issue_stage_pkg::*;

    logic [31:0]      rf_q [NREGS];
    logic [1:0][31:0] operand;
    logic [1:0]       src_used;
    issue_pkt_t       out_q;
    logic             out_valid;
    logic             out_long;
    logic             retire;
    logic             hazard;
    logic             block;
    logic             accept;

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_i && (wb_dest_i != 5'd0)) begin
            rf_q[wb_dest_i] <= wb_data_i;
        end
    end

    always_comb begin
        operand  = '0;
        src_used = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            src_used[k] = !dec_imm_valid_i[k] && (dec_src_i[k] != 5'd0);
            if (dec_imm_valid_i[k]) begin
                operand[k] = dec_imm_i;
            end else if (dec_src_i[k] == 5'd0) begin
                operand[k] = '0;
            end else if (wb_i && (wb_dest_i == dec_src_i[k])) begin
                operand[k] = wb_data_i;
            end else begin
                operand[k] = rf_q[dec_src_i[k]];
            end
        end
    end

    assign out_valid = |out_q.unit;
    assign out_long  = |(out_q.unit & LONG_MASK);
    assign retire    = out_valid && !stall_i && !flush_i && !branch_flush_i;

    scoreboard #(
        .CNT_W (CNT_W)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .flush_i       (flush_i),
        .retire_i      (retire),
        .retire_dest_i (out_q.dest),
        .retire_long_i (out_long),
        .wb_i          (wb_i),
        .wb_dest_i     (wb_dest_i),
        .src_i         (dec_src_i),
        .src_used_i    (src_used),
        .dec_dest_i    (dec_dest_i),
        .pend_valid_i  (out_valid),
        .pend_long_i   (out_long),
        .pend_dest_i   (out_q.dest),
        .hazard_o      (hazard),
        .block_o       (block)
    );

    assign dec_ready_o = !hazard && !block && (!stall_i || !out_valid) &&
                         !flush_i && !branch_flush_i;
    assign accept      = dec_valid_i && dec_ready_o;

    // Accept is allowed under stall only when the register is empty, so it
    // is checked before the stall hold to avoid dropping that instruction.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_q <= '0;
        end else if (flush_i || branch_flush_i) begin
            out_q.unit <= '0;
        end else if (accept) begin
            out_q.src       <= dec_src_i;
            out_q.imm_valid <= dec_imm_valid_i;
            out_q.operand   <= operand;
            out_q.unit      <= dec_unit_i;
            out_q.uop       <= dec_uop_i;
            out_q.ipacket   <= dec_ipacket_i;
            out_q.dest      <= dec_dest_i;
        end else if (!stall_i) begin
            out_q.unit <= '0;
        end
    end

    assign iss_src_o        = out_q.src;
    assign iss_imm_valid_o  = out_q.imm_valid;
    assign iss_operand_o    = out_q.operand;
    assign iss_unit_valid_o = out_q.unit;
    assign iss_uop_o        = out_q.uop;
    assign iss_ipacket_o    = out_q.ipacket;

endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage
//   Directed self-checking bench for issue_stage. Inputs change 1 ns after
//   the rising edge; outputs are compared 1 ns later, away from the edge.
module tb_issue_stage;

    localparam logic [7:0] U_ALU  = 8'b0000_0001;
    localparam logic [7:0] U_LOAD = 8'b0000_0010;

    logic            clk_i = 1'b0;
    logic            rst_n_i;
    logic            dec_valid_i;
    logic            dec_ready_o;
    logic [1:0][4:0] dec_src_i;
    logic [1:0]      dec_imm_valid_i;
    logic [31:0]     dec_imm_i;
    logic [4:0]      dec_dest_i;
    logic [7:0]      dec_unit_i;
    logic [7:0]      dec_uop_i;
    logic [31:0]     dec_ipacket_i;
    logic [1:0][4:0] iss_src_o;
    logic [1:0]      iss_imm_valid_o;
    logic [1:0][31:0] iss_operand_o;
    logic [7:0]      iss_unit_valid_o;
    logic [7:0]      iss_uop_o;
    logic [31:0]     iss_ipacket_o;
    logic            stall_i;
    logic            flush_i;
    logic            branch_flush_i;
    logic            wb_i;
    logic [4:0]      wb_dest_i;
    logic [31:0]     wb_data_i;

    int checks   = 0;
    int failures = 0;

    issue_stage dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .dec_valid_i      (dec_valid_i),
        .dec_ready_o      (dec_ready_o),
        .dec_src_i        (dec_src_i),
        .dec_imm_valid_i  (dec_imm_valid_i),
        .dec_imm_i        (dec_imm_i),
        .dec_dest_i       (dec_dest_i),
        .dec_unit_i       (dec_unit_i),
        .dec_uop_i        (dec_uop_i),
        .dec_ipacket_i    (dec_ipacket_i),
        .iss_src_o        (iss_src_o),
        .iss_imm_valid_o  (iss_imm_valid_o),
        .iss_operand_o    (iss_operand_o),
        .iss_unit_valid_o (iss_unit_valid_o),
        .iss_uop_o        (iss_uop_o),
        .iss_ipacket_o    (iss_ipacket_o),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .branch_flush_i   (branch_flush_i),
        .wb_i             (wb_i),
        .wb_dest_i        (wb_dest_i),
        .wb_data_i        (wb_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] immv,
                           input logic [31:0] imm, input logic [4:0] dest, input logic [7:0] unit,
                           input logic [7:0] uop, input logic [31:0] pkt);
        dec_valid_i     = 1'b1;
        dec_src_i[0]    = s0;
        dec_src_i[1]    = s1;
        dec_imm_valid_i = immv;
        dec_imm_i       = imm;
        dec_dest_i      = dest;
        dec_unit_i      = unit;
        dec_uop_i       = uop;
        dec_ipacket_i   = pkt;
    endtask

    task automatic idle();
        dec_valid_i     = 1'b0;
        dec_src_i       = '0;
        dec_imm_valid_i = '0;
        dec_imm_i       = '0;
        dec_dest_i      = '0;
        dec_unit_i      = '0;
        dec_uop_i       = '0;
        dec_ipacket_i   = '0;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] d, input logic [31:0] data);
        wb_i      = en;
        wb_dest_i = d;
        wb_data_i = data;
    endtask

    initial begin
        rst_n_i        = 1'b0;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        branch_flush_i = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        idle();
        step();
        step();
        rst_n_i = 1'b1;
        settle();
        check("rst_unit_valid", 64'(iss_unit_valid_o), 64'h0);
        check("rst_operand",    64'(iss_operand_o), 64'h0);
        check("rst_uop_pkt",    {24'h0, iss_uop_o, iss_ipacket_o}, 64'h0);
        check("rst_ready",      64'(dec_ready_o), 64'h1);

        // Write x5, then ADD x6,x5,imm 4
        set_wb(1'b1, 5'd5, 32'h1234);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        present(5'd5, 5'd0, 2'b10, 32'd4, 5'd6, U_ALU, 8'h11, 32'hA1);
        settle();
        check("add_ready", 64'(dec_ready_o), 64'h1);
        step();
        idle();
        settle();
        check("add_unit", 64'(iss_unit_valid_o), 64'(U_ALU));
        check("add_op0",  64'(iss_operand_o[0]), 64'h1234);
        check("add_op1",  64'(iss_operand_o[1]), 64'h4);
        check("add_meta", {16'h0, iss_uop_o, iss_ipacket_o, 3'b0, iss_src_o[0]}, {16'h0, 8'h11, 32'hA1, 8'h05});
        step();
        check("add_drained", 64'(iss_unit_valid_o), 64'h0);

        // LOAD x7, then ADD x8,x7,x1 waits for the x7 writeback
        present(5'd0, 5'd0, 2'b11, 32'h100, 5'd7, U_LOAD, 8'h21, 32'hB1);
        settle();
        step();
        present(5'd7, 5'd1, 2'b00, 32'd0, 5'd8, U_ALU, 8'h22, 32'hB2);
        settle();
        check("raw_block_outreg", 64'(dec_ready_o), 64'h0);
        step();
        check("raw_block_cnt1", 64'(dec_ready_o), 64'h0);
        step();
        check("raw_block_cnt2", 64'(dec_ready_o), 64'h0);
        set_wb(1'b1, 5'd7, 32'hCAFE);
        settle();
        check("raw_block_wb_cycle", 64'(dec_ready_o), 64'h0);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        settle();
        check("raw_release", 64'(dec_ready_o), 64'h1);
        step();
        idle();
        settle();
        check("raw_issue_unit", 64'(iss_unit_valid_o), 64'(U_ALU));
        check("raw_issue_op0",  64'(iss_operand_o[0]), 64'hCAFE);
        check("raw_issue_op1",  64'(iss_operand_o[1]), 64'h0);
        step();

        // Write-through: wb x3 in the same cycle decode reads x3 twice
        present(5'd3, 5'd3, 2'b00, 32'd0, 5'd11, U_ALU, 8'h31, 32'hC1);
        set_wb(1'b1, 5'd3, 32'h55AA);
        settle();
        check("wt_ready", 64'(dec_ready_o), 64'h1);
        step();
        idle();
        set_wb(1'b0, 5'd0, 32'd0);
        settle();
        check("wt_op0", 64'(iss_operand_o[0]), 64'h55AA);
        check("wt_op1", 64'(iss_operand_o[1]), 64'h55AA);
        step();

        // Stall for 3 cycles with a valid output and a waiting instruction
        present(5'd5, 5'd0, 2'b10, 32'd7, 5'd12, U_ALU, 8'h33, 32'hD1);
        step();
        present(5'd0, 5'd0, 2'b11, 32'd9, 5'd13, U_ALU, 8'h44, 32'hD2);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("stall_ready", 64'(dec_ready_o), 64'h0);
            check("stall_hold",  {8'h0, iss_unit_valid_o, iss_uop_o, iss_operand_o[0], iss_ipacket_o[7:0]},
                                 {8'h0, U_ALU, 8'h33, 32'h1234, 8'hD1});
            step();
        end
        stall_i = 1'b0;
        settle();
        check("stall_release_ready", 64'(dec_ready_o), 64'h1);
        step();
        idle();
        settle();
        check("stall_next_issue", {iss_unit_valid_o, iss_uop_o, iss_operand_o[1]}, {U_ALU, 8'h44, 32'd9});
        step();
        check("stall_no_dup", 64'(iss_unit_valid_o), 64'h0);

        // Branch flush drops the held instruction
        present(5'd0, 5'd0, 2'b11, 32'd1, 5'd15, U_ALU, 8'h55, 32'hE1);
        step();
        idle();
        branch_flush_i = 1'b1;
        present(5'd0, 5'd0, 2'b11, 32'd2, 5'd16, U_ALU, 8'h56, 32'hE2);
        settle();
        check("bflush_ready", 64'(dec_ready_o), 64'h0);
        step();
        branch_flush_i = 1'b0;
        idle();
        settle();
        check("bflush_unit", 64'(iss_unit_valid_o), 64'h0);

        // Two LOADs to x9, then flush releases a reader of x9
        present(5'd0, 5'd0, 2'b11, 32'h200, 5'd9, U_LOAD, 8'h61, 32'hF1);
        step();
        present(5'd0, 5'd0, 2'b11, 32'h204, 5'd9, U_LOAD, 8'h62, 32'hF2);
        step();
        idle();
        flush_i = 1'b1;
        settle();
        check("flush_ready", 64'(dec_ready_o), 64'h0);
        step();
        flush_i = 1'b0;
        settle();
        check("flush_unit", 64'(iss_unit_valid_o), 64'h0);
        present(5'd9, 5'd0, 2'b00, 32'd0, 5'd14, U_ALU, 8'h63, 32'hF3);
        settle();
        check("flush_reader_ready", 64'(dec_ready_o), 64'h1);
        step();
        idle();
        settle();
        check("flush_reader_issue", {iss_unit_valid_o, iss_uop_o, iss_operand_o[0]}, {U_ALU, 8'h63, 32'h0});
        step();

        // Seven ops to x10 saturate its counter; the eighth waits for a wb
        for (int i = 0; i < 7; i++) begin
            present(5'd0, 5'd0, 2'b11, 32'(i), 5'd10, U_ALU, 8'(8'h70 + i), 32'h0);
            settle();
            check("sat_fill_ready", 64'(dec_ready_o), 64'h1);
            step();
        end
        idle();
        step();
        present(5'd0, 5'd0, 2'b11, 32'h8, 5'd10, U_ALU, 8'h7F, 32'h0);
        settle();
        check("sat_block", 64'(dec_ready_o), 64'h0);
        step();
        check("sat_block_hold", 64'(dec_ready_o), 64'h0);
        set_wb(1'b1, 5'd10, 32'h77);
        settle();
        check("sat_block_wb_cycle", 64'(dec_ready_o), 64'h0);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        settle();
        check("sat_release", 64'(dec_ready_o), 64'h1);
        step();
        idle();
        settle();
        check("sat_issue", {iss_unit_valid_o, iss_uop_o}, {U_ALU, 8'h7F});
        step();

        // Reset mid-operation clears the register file
        rst_n_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        present(5'd5, 5'd3, 2'b00, 32'd0, 5'd1, U_ALU, 8'h90, 32'h0);
        settle();
        check("rst2_ready", 64'(dec_ready_o), 64'h1);
        step();
        idle();
        settle();
        check("rst2_operands", 64'(iss_operand_o), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
